// File: rtl/dff_bank_pkg.sv
// Shared types, default sizing and the round-robin scan used by the
// write arbiter in front of the DFF register bank.
package dff_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEF_N         = 4;
  localparam int DEF_W         = 8;
  localparam int DEF_AW        = 3;
  localparam int DEF_MAX_BURST = 4;

  // The scan is sized for the largest supported requester count; smaller
  // arbiters zero-pad their request vector into it.
  localparam int MAX_N  = 8;
  localparam int SCAN_W = 3;

  // Returns {found, index} of the first set request at or above ptr,
  // wrapping modulo n.
  function automatic logic [SCAN_W:0] rr_next(
    input logic [MAX_N-1:0]  req,
    input logic [SCAN_W-1:0] ptr,
    input int                n
  );
    logic              found;
    logic [SCAN_W-1:0] idx;
    int                k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < MAX_N; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if ((i < n) && !found && req[k[SCAN_W-1:0]]) begin
        found = 1'b1;
        idx   = k[SCAN_W-1:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or above the
// pointer, with wrap, as both a one-hot vector and an index.
module rr_pick
  import dff_bank_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [MAX_N-1:0] req_ext;
  logic [SCAN_W:0]  pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign pick   = rr_next(req_ext, SCAN_W'(ptr), N);
  assign valid  = pick[SCAN_W];
  assign idx    = IW'(pick[SCAN_W-1:0]);
  assign onehot = valid ? (N'(1) << idx) : '0;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter with optional capped locked bursts in front of
// a shared DFF register bank, plus a registered read port.
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int W         = DEF_W,
  parameter int AW        = DEF_AW,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int IW        = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  input  logic [N*W-1:0]  wdata,
  input  logic [N*AW-1:0] waddr,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   owner,
  output logic            busy,
  input  logic [AW-1:0]   raddr,
  output logic [W-1:0]    rdata
);

  localparam int DEPTH = 2 ** AW;
  localparam int CW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);

  state_t        state, state_n;
  logic [N-1:0]  gnt_n;
  logic [IW-1:0] owner_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] owner_inc;
  logic [IW-1:0] scan_ptr;
  logic [CW-1:0] cnt, cnt_n;
  logic          wr_en;
  logic [W-1:0]  wdata_g;
  logic [AW-1:0] waddr_g;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [W-1:0]  bank [DEPTH];

  // Explicit compare so non-power-of-two N wraps correctly.
  assign owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  // On release the scan starts just past the current owner, matching the
  // pointer value that is being committed on the same edge.
  assign scan_ptr = (state == GRANT) ? owner_inc : ptr;

  assign wdata_g = wdata[owner*W +: W];
  assign waddr_g = waddr[owner*AW +: AW];
  assign busy    = |gnt;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (scan_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    ptr_n   = ptr;
    cnt_n   = cnt;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = GRANT;
          gnt_n   = pick_onehot;
          owner_n = pick_idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        wr_en = req[owner];
        if (req[owner] && lock[owner] && (cnt < BURST_LAST)) begin
          cnt_n = cnt + 1'b1;
        end else begin
          ptr_n = owner_inc;
          cnt_n = '0;
          if (pick_valid) begin
            gnt_n   = pick_onehot;
            owner_n = pick_idx;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  // Reads sample the pre-edge contents, so a same-edge write shows up on
  // the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      rdata <= '0;
    end else begin
      if (wr_en) bank[waddr_g] <= wdata_g;
      rdata <= bank[raddr];
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed vector bench for dff_bank_arbiter: a table of cycle-by-cycle
// vectors followed by hand-written reset and pointer sequences.
module tb_dff_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [11:0] waddr;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [2:0]  raddr;
  logic [7:0]  rdata;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [11:0] waddr;
    logic [2:0]  raddr;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs[$];

  // Requester i writes data byte i to address i unless overridden.
  localparam logic [31:0] DATA_DEF = 32'hD3C2B1A0;
  localparam logic [11:0] ADDR_DEF = 12'h688;

  dff_bank_arbiter #(
    .N         (4),
    .W         (8),
    .AW        (3),
    .MAX_BURST (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .waddr (waddr),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .raddr (raddr),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic [3:0] rq, input logic [3:0] lk,
    input logic [31:0] wd, input logic [11:0] wa, input logic [2:0] ra,
    input logic [3:0] eg, input logic [1:0] eo, input logic [7:0] er
  );
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.wdata = wd; v.waddr = wa;
    v.raddr = ra; v.gnt = eg; v.owner = eo; v.rdata = er;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic r, input logic [3:0] rq, input logic [3:0] lk,
    input logic [31:0] wd, input logic [11:0] wa, input logic [2:0] ra
  );
    rst   = r;
    req   = rq;
    lock  = lk;
    wdata = wd;
    waddr = wa;
    raddr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] eg,
                             input logic [1:0] eo, input logic [7:0] er);
    check({tag, ".gnt"},   32'(gnt),   32'(eg));
    check({tag, ".busy"},  32'(busy),  32'(|eg));
    if (eg != 4'h0) check({tag, ".owner"}, 32'(owner), 32'(eo));
    check({tag, ".rdata"}, 32'(rdata), 32'(er));
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; wdata = '0; waddr = '0; raddr = '0;

    // Reset with all requesters active, then an 8-grant round-robin sweep.
    vecs.push_back(mk(1, 4'hF, 4'h0, DATA_DEF, ADDR_DEF, 3'd0, 4'h0, 2'd0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'h0, DATA_DEF, ADDR_DEF, 3'd0, 4'h0, 2'd0, 8'h00));
    vecs.push_back(mk(0, 4'hF, 4'h0, DATA_DEF, ADDR_DEF, 3'd0, 4'h1, 2'd0, 8'h00));
    vecs.push_back(mk(0, 4'hF, 4'h0, DATA_DEF, ADDR_DEF, 3'd0, 4'h2, 2'd1, 8'h00));
    vecs.push_back(mk(0, 4'hF, 4'h0, DATA_DEF, ADDR_DEF, 3'd0, 4'h4, 2'd2, 8'hA0));
    vecs.push_back(mk(0, 4'hF, 4'h0, DATA_DEF, ADDR_DEF, 3'd1, 4'h8, 2'd3, 8'hB1));
    vecs.push_back(mk(0, 4'hF, 4'h0, DATA_DEF, ADDR_DEF, 3'd2, 4'h1, 2'd0, 8'hC2));
    vecs.push_back(mk(0, 4'hF, 4'h0, DATA_DEF, ADDR_DEF, 3'd3, 4'h2, 2'd1, 8'hD3));
    vecs.push_back(mk(0, 4'hF, 4'h0, DATA_DEF, ADDR_DEF, 3'd3, 4'h4, 2'd2, 8'hD3));
    vecs.push_back(mk(0, 4'hF, 4'h0, DATA_DEF, ADDR_DEF, 3'd3, 4'h8, 2'd3, 8'hD3));
    // Locked burst by requester 0: four grants, four writes, then release to 1.
    vecs.push_back(mk(0, 4'h3, 4'h1, DATA_DEF,     ADDR_DEF, 3'd0, 4'h1, 2'd0, 8'hA0));
    vecs.push_back(mk(0, 4'h3, 4'h1, 32'hD3C2B101, ADDR_DEF, 3'd0, 4'h1, 2'd0, 8'hA0));
    vecs.push_back(mk(0, 4'h3, 4'h1, 32'hD3C2B102, ADDR_DEF, 3'd0, 4'h1, 2'd0, 8'h01));
    vecs.push_back(mk(0, 4'h3, 4'h1, 32'hD3C2B103, ADDR_DEF, 3'd0, 4'h1, 2'd0, 8'h02));
    vecs.push_back(mk(0, 4'h3, 4'h1, 32'hD3C2B104, ADDR_DEF, 3'd0, 4'h2, 2'd1, 8'h03));
    vecs.push_back(mk(0, 4'h3, 4'h1, 32'hD3C2B104, ADDR_DEF, 3'd0, 4'h1, 2'd0, 8'h04));
    // Requester 2 drops its request during its grant: addr 5 must stay 0.
    vecs.push_back(mk(0, 4'h4, 4'h0, 32'hD3A5B1A0, 12'h748, 3'd5, 4'h4, 2'd2, 8'h00));
    vecs.push_back(mk(0, 4'h0, 4'h0, 32'hD3A5B1A0, 12'h748, 3'd5, 4'h0, 2'd0, 8'h00));
    vecs.push_back(mk(0, 4'h0, 4'h0, 32'hD3A5B1A0, 12'h748, 3'd5, 4'h0, 2'd0, 8'h00));
    // Lone requester 1 writes 11 then 3C to addr 2 while reading it.
    vecs.push_back(mk(0, 4'h2, 4'h0, 32'hD3C211A0, 12'h690, 3'd2, 4'h2, 2'd1, 8'hC2));
    vecs.push_back(mk(0, 4'h2, 4'h0, 32'hD3C211A0, 12'h690, 3'd2, 4'h2, 2'd1, 8'hC2));
    vecs.push_back(mk(0, 4'h2, 4'h0, 32'hD3C23CA0, 12'h690, 3'd2, 4'h2, 2'd1, 8'h11));
    vecs.push_back(mk(0, 4'h0, 4'h0, 32'hD3C23CA0, 12'h690, 3'd2, 4'h0, 2'd0, 8'h3C));
    // Locked burst interrupted by reset on its second grant cycle.
    vecs.push_back(mk(0, 4'h1, 4'h1, 32'hD3C23C77, ADDR_DEF, 3'd0, 4'h1, 2'd0, 8'h04));
    vecs.push_back(mk(0, 4'h1, 4'h1, 32'hD3C23C77, ADDR_DEF, 3'd0, 4'h1, 2'd0, 8'h04));
    vecs.push_back(mk(1, 4'hA, 4'h0, DATA_DEF,     ADDR_DEF, 3'd0, 4'h0, 2'd0, 8'h00));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].lock,
                    vecs[i].wdata, vecs[i].waddr, vecs[i].raddr);
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].owner, vecs[i].rdata);
    end

    // Every bank entry reads back as zero after the mid-burst reset.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 4'h0, 4'h0, DATA_DEF, ADDR_DEF, 3'(k));
      checkOutput($sformatf("clr%0d", k), 4'h0, 2'd0, 8'h00);
    end

    // Pointer restarted at 0: 1010 picks 1 first, then 3, then idles.
    applyStimulus(1'b0, 4'hA, 4'h0, DATA_DEF, ADDR_DEF, 3'd0);
    checkOutput("ptr0", 4'h2, 2'd1, 8'h00);
    applyStimulus(1'b0, 4'hA, 4'h0, DATA_DEF, ADDR_DEF, 3'd0);
    checkOutput("ptr1", 4'h8, 2'd3, 8'h00);
    applyStimulus(1'b0, 4'h0, 4'h0, DATA_DEF, ADDR_DEF, 3'd1);
    checkOutput("ptr2", 4'h0, 2'd0, 8'hB1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
